// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cpu_pkg                                                          |
// | Desc     : Shared types and width constants for the memory port arbiter.   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int c_ADDR_W       = 32;
    localparam int c_DATA_W       = 32;
    localparam int c_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Width needed to hold 0..limit; a zero limit still gets a 1-bit counter.
    function automatic int starve_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mem_arb_grant                                                    |
// | Desc     : D-priority grant with an IF anti-starvation counter.             |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module mem_arb_grant
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = c_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_valid,
    input  logic d_valid,
    output logic grant_if,
    output logic grant_d
);

    localparam int                 c_CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               w_force_if;

    assign w_force_if = (STARVE_LIMIT != 0) && (r_starve_cnt == c_LIMIT) && if_valid;

    always_comb begin
        grant_d  = idle && d_valid && !w_force_if;
        grant_if = idle && if_valid && !grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (idle) begin
            if (!if_valid || grant_if) begin
                r_starve_cnt <= '0;
            end else if (grant_d && (r_starve_cnt != c_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                 |
// | Desc     : Shares a single-port word memory between IF and D requesters.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = c_ADDR_W,
    parameter int DATA_W       = c_DATA_W,
    parameter int STARVE_LIMIT = c_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_r_enable,
    output logic              mem_w_enable,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_idle;
    logic w_grant_if;
    logic w_grant_d;
    logic w_accept;
    logic w_rsp_ready;

    // Readies are masked during reset so nothing can handshake while rst is high.
    assign w_idle = (r_state == IDLE) && !rst;

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .idle     (w_idle),
        .if_valid (if_req_valid),
        .d_valid  (d_req_valid),
        .grant_if (w_grant_if),
        .grant_d  (w_grant_d)
    );

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;
    assign w_accept     = w_grant_if || w_grant_d;
    assign w_rsp_ready  = (r_owner == OWN_IF) ? if_rsp_ready : d_rsp_ready;
    assign busy         = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = RESP;
            RESP:    if (w_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWN_D;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner <= w_grant_d ? OWN_D : OWN_IF;
                r_we    <= w_grant_d && d_req_we;
                r_addr  <= (w_grant_d ? d_req_addr : if_req_addr) & c_ALIGN_MASK;
                r_wdata <= w_grant_d ? d_req_wdata : '0;
            end
        end
    end

    // Enables are only ever raised in ISSUE, leaving mem_rdata stable through RESP.
    always_comb begin
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        mem_r_enable = 1'b0;
        mem_w_enable = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = '0;
        case (r_state)
            ISSUE: begin
                mem_r_enable = !r_we;
                mem_w_enable = r_we;
            end
            RESP: begin
                if (r_owner == OWN_IF) begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = r_we ? '0 : mem_rdata;
                end else begin
                    d_rsp_valid = 1'b1;
                    d_rsp_data  = r_we ? '0 : mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
